// File: rtl/toggle_hs_pkg.sv
// Types and defaults shared by both ends of the toggle request/acknowledge link.
package toggle_hs_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TIMEOUT     = 255;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  // Bits needed to count 0..timeout. Always at least 1, so a disabled timer still has a legal width.
  function automatic int unsigned timer_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level. It resets to 0.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: flops are written with <= so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_chain <= '0;
    else      r_chain <= {r_chain[STAGES-2:0], d};
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/toggle_handshake_tx.sv
// Sending end of a two-phase toggle handshake. It registers one word per request phase
// and waits for the synchronized acknowledge phase before it accepts the next word.
module toggle_handshake_tx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             busy,
  input  logic             err_clr,
  output logic             timeout_err,
  output logic             proto_err
);

  localparam int unsigned TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_tx_req;
  logic [TW-1:0]    r_timer;
  logic             r_timeout_err;
  logic             r_proto_err;
  logic             w_ack_s;
  logic             w_accept;
  logic             w_ack_match;
  logic             w_timeout_hit;
  logic             w_proto_hit;

  bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (tx_ack),
    .q   (w_ack_s)
  );

  assign in_ready    = (r_state == IDLE);
  assign busy        = (r_state == WAIT_ACK);
  assign w_accept    = in_valid & in_ready;
  assign w_ack_match = (w_ack_s == r_tx_req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:     if (w_accept)    w_state_next = WAIT_ACK;
      WAIT_ACK: if (w_ack_match) w_state_next = IDLE;
      default:                   w_state_next = IDLE;
    endcase
  end

  // The request phase is a T-flop driven by accept, so it is never reverted once a word is launched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data <= '0;
      r_tx_req  <= 1'b0;
    end else if (w_accept) begin
      r_tx_data <= in_data;
      r_tx_req  <= ~r_tx_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_timer <= '0;
    else if (w_accept)                    r_timer <= '0;
    else if (busy && r_timer != TIMER_MAX) r_timer <= r_timer + TW'(1);
  end

  assign w_timeout_hit = (TIMEOUT != 0) && busy && (r_timer == TIMER_LAST);
  assign w_proto_hit   = in_ready && !w_ack_match;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_err <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout_hit | (r_timeout_err & ~err_clr);
      r_proto_err   <= w_proto_hit   | (r_proto_err   & ~err_clr);
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_req      = r_tx_req;
  assign timeout_err = r_timeout_err;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_toggle_handshake_tx.sv
// Directed bench for toggle_handshake_tx with a short timeout, so that the timeout path can be exercised.
module tb_toggle_handshake_tx;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 8;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         err_clr  = 1'b0;
  logic         man_ack  = 1'b0;
  logic         resp_en  = 1'b0;
  logic         resp_ack = 1'b0;
  logic         tx_ack;
  logic         in_ready;
  logic [W-1:0] tx_data;
  logic         tx_req;
  logic         busy;
  logic         timeout_err;
  logic         proto_err;

  int errors = 0;
  int checks = 0;

  assign tx_ack = resp_en ? resp_ack : man_ack;

  toggle_handshake_tx #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ack      (tx_ack),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  // The receiver model returns the request phase one cycle after it sees the phase.
  always @(posedge clk) resp_ack <= tx_req;

  int           cyc = 0;
  logic         mon_en = 1'b0;
  logic         prev_req = 1'b0;
  logic [W-1:0] got_data[$];
  logic         got_req[$];
  int           got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && tx_req !== prev_req) begin
      got_data.push_back(tx_data);
      got_req.push_back(tx_req);
      got_cyc.push_back(cyc);
    end
    prev_req <= tx_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] words [3];
    int n;
    words[0] = 8'h3C;
    words[1] = 8'h5A;
    words[2] = 8'hF0;

    // 1: reset
    step(3);
    check("rst_tx_req",   tx_req,      0);
    check("rst_tx_data",  tx_data,     0);
    check("rst_in_ready", in_ready,    1);
    check("rst_busy",     busy,        0);
    check("rst_timeout",  timeout_err, 0);
    check("rst_proto",    proto_err,   0);
    rst = 1'b1;
    step(1);
    check("rel_in_ready", in_ready, 1);

    // 2: single word, inputs ignored while busy, ack return latency
    in_data = 8'hA5; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("t2_tx_req",   tx_req,   1);
    check("t2_tx_data",  tx_data,  8'hA5);
    check("t2_busy",     busy,     1);
    check("t2_in_ready", in_ready, 0);
    in_data = 8'hFF; in_valid = 1'b1;
    step(2);
    in_valid = 1'b0;
    check("t2_hold_data", tx_data, 8'hA5);
    check("t2_hold_req",  tx_req,  1);
    man_ack = 1'b1;
    step(SS);
    check("t2_ready_early", in_ready, 0);
    step(1);
    check("t2_ready_on_time", in_ready, 1);
    check("t2_proto", proto_err, 0);

    // 3: back-to-back words with the auto-responder
    rst = 1'b0; man_ack = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    resp_en = 1'b1; mon_en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      n = 0;
      while (!in_ready && n < 20) begin
        step(1);
        n++;
      end
      check("t3_wait_ready", (n < 20), 1);
      step(1);
    end
    in_valid = 1'b0;
    step(8);
    mon_en = 1'b0;
    check("t3_count", got_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_data%0d", i), (i < got_data.size()) ? got_data[i] : 8'hxx, words[i]);
      check($sformatf("t3_req%0d", i),  (i < got_req.size())  ? got_req[i]  : 1'bx,  (i % 2 == 0) ? 1 : 0);
    end
    if (got_cyc.size() == 3) begin
      check("t3_gap01", got_cyc[1] - got_cyc[0], SS + 3);
      check("t3_gap12", got_cyc[2] - got_cyc[1], SS + 3);
    end
    check("t3_idle",    in_ready,    1);
    check("t3_timeout", timeout_err, 0);
    check("t3_proto",   proto_err,   0);
    man_ack = 1'b1;
    resp_en = 1'b0;

    // 4: timeout, late ack, clear
    in_data = 8'hC3; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("t4_tx_req", tx_req, 0);
    step(TO - 1);
    check("t4_to_early", timeout_err, 0);
    step(1);
    check("t4_to_set",  timeout_err, 1);
    check("t4_busy",    busy,        1);
    step(10);
    check("t4_still_busy", busy,        1);
    check("t4_req_kept",   tx_req,      0);
    check("t4_sticky",     timeout_err, 1);
    man_ack = 1'b0;
    step(SS + 1);
    check("t4_late_done",  in_ready,    1);
    check("t4_still_set",  timeout_err, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_cleared", timeout_err, 0);
    check("t4_proto",   proto_err,   0);

    // 5: protocol error while idle, set beats clear
    man_ack = 1'b1;
    step(SS);
    check("t5_proto_early", proto_err, 0);
    step(1);
    check("t5_proto_set", proto_err, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t5_set_wins", proto_err, 1);
    check("t5_no_state", in_ready,  1);
    check("t5_req_same", tx_req,    0);
    man_ack = 1'b0;
    step(SS + 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t5_cleared", proto_err, 0);

    // 6: asynchronous reset mid-transfer, then a clean word
    in_data = 8'h96; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("t6_busy", busy,   1);
    check("t6_req",  tx_req, 1);
    step(1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_req",   tx_req,   0);
    check("t6_rst_busy",  busy,     0);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_data",  tx_data,  0);
    step(2);
    rst = 1'b1;
    step(1);
    in_data = 8'h77; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("t6_new_req",  tx_req,  1);
    check("t6_new_data", tx_data, 8'h77);
    man_ack = 1'b1;
    step(SS + 1);
    check("t6_done",  in_ready,  1);
    check("t6_proto", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
